serial_adder_decoder: RTL and testbench

- Parametrised bit-serial adder. Each cycle it sums one bit using a 3:8 minterm decoder: sum = m1|m2|m4|m7, carry = m3|m5|m6|m7.
- Generalises the single-bit decoder full adder to WIDTH-bit operands, with a start/busy/done handshake and a signed-overflow flag.
- Sits in the arithmetic library as a low-area multi-cycle adder for slow datapaths.

---
 rtl/serial_adder_decoder_if.sv | 35 +++
 rtl/serial_adder_decoder.sv | 132 +++++++++++++
 tb/tb_serial_adder_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_decoder_if.sv
// Handshake and operand/result bundle for serial_adder_decoder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_decoder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [7:0]       m;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf, m
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf, m
  );
endinterface

// File: rtl/serial_adder_decoder.sv
// Bit-serial WIDTH-bit adder built around a 3:8 minterm decoder, one bit per cycle.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_decoder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       m_dec;
  logic             sum_bit;
  logic             carry_nxt;
  logic             accept;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] res_shifted;

  // Decoder index is {a bit, b bit, carry}; sum and carry are ORs of minterms.
  always_comb begin
    m_dec       = 8'b1 << {a_sh_q[0], b_sh_q[0], carry_q};
    sum_bit     = m_dec[1] | m_dec[2] | m_dec[4] | m_dec[7];
    carry_nxt   = m_dec[3] | m_dec[5] | m_dec[6] | m_dec[7];
    res_shifted = {sum_bit, res_q[WIDTH-1:1]};
    accept      = bus.start && ((state_q == IDLE) || (state_q == DONE));
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  always_comb begin
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_load = bus.sub ? 1'b1 : bus.cin;
  end
`else
  always_comb begin
    b_load     = bus.b;
    carry_load = bus.cin;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = b_load;
      carry_d = carry_load;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      res_d   = res_shifted;
      carry_d = carry_nxt;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_MSB) c_msb_d = carry_nxt;
      // Published results change only here, so they hold through the next run.
      if (cnt_q == CNT_LAST) begin
        sum_d  = res_shifted;
        cout_d = carry_nxt;
        ovf_d  = c_msb_q ^ carry_nxt;
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.m    = (state_q == RUN) ? m_dec : 8'h00;
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end
endmodule

// File: tb/tb_serial_adder_decoder.sv
// Directed self-checking bench for serial_adder_decoder at WIDTH=8.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_decoder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   assert_count;
  int   fail_count;

  serial_adder_decoder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_decoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v, input logic cin_v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.cin   = cin_v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a_v;
    bus.b     = ~b_v;
    bus.cin   = ~cin_v;
  endtask

  // Returns the number of negedges seen before done; exceeds 64 on timeout.
  task automatic waitDone(output int cycles);
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles <= 64) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else cycles++;
    end
  endtask

  task automatic runVector(input string tag, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                           input logic cin_v, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
    int lat;
    applyStimulus(a_v, b_v, cin_v);
    waitDone(lat);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(WIDTH));
    checkOutput({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
    checkOutput({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
    checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit saw_done;
    assert_count = 0;
    fail_count   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.sum", 32'(bus.sum), 32'd0);
    checkOutput("reset.cout", 32'(bus.cout), 32'd0);
    checkOutput("reset.ovf", 32'(bus.ovf), 32'd0);
    checkOutput("reset.m", 32'(bus.m), 32'd0);
    rst_n = 1'b1;

    runVector("add5A33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    runVector("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runVector("add7F00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    runVector("addAA55c", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    runVector("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Minterm trace: 1+0+1 gives index 5, then 0+0+1 gives index 1, then index 0.
    applyStimulus(8'h01, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("mterm.busy", 32'(bus.busy), 32'd1);
    checkOutput("mterm.m0", 32'(bus.m), 32'h20);
    @(negedge clk);
    checkOutput("mterm.m1", 32'(bus.m), 32'h02);
    @(negedge clk);
    checkOutput("mterm.m2", 32'(bus.m), 32'h01);
    waitDone(lat);
    checkOutput("mterm.latency", 32'(lat), 32'(WIDTH - 3));
    checkOutput("mterm.sum", 32'(bus.sum), 32'h02);
    checkOutput("mterm.doneM", 32'(bus.m), 32'd0);
    checkOutput("mterm.doneBusy", 32'(bus.busy), 32'd0);

    // A start pulse during RUN must not disturb the in-flight operands.
    applyStimulus(8'h5A, 8'h33, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(lat);
    checkOutput("ignore.latency", 32'(lat), 32'(WIDTH - 2));
    checkOutput("ignore.sum", 32'(bus.sum), 32'h8D);
    checkOutput("ignore.ovf", 32'(bus.ovf), 32'd1);

    // Start held in DONE launches the next operation with no IDLE gap.
    bus.start = 1'b1;
    bus.a     = 8'h7F;
    bus.b     = 8'h00;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("b2b.busy", 32'(bus.busy), 32'd1);
    checkOutput("b2b.holdSum", 32'(bus.sum), 32'h8D);
    waitDone(lat);
    checkOutput("b2b.latency", 32'(lat), 32'(WIDTH - 1));
    checkOutput("b2b.sum", 32'(bus.sum), 32'h80);
    checkOutput("b2b.cout", 32'(bus.cout), 32'd0);
    checkOutput("b2b.ovf", 32'(bus.ovf), 32'd1);

    // Reset in the middle of a run aborts it without a done pulse.
    applyStimulus(8'hAA, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.sum", 32'(bus.sum), 32'd0);
    checkOutput("abort.m", 32'(bus.m), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort.noDone", 32'(saw_done), 32'd0);
    runVector("afterAbort", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    runVector("sub1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
    runVector("sub8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    runVector("sub0503", 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0);
    bus.sub = 1'b0;
    runVector("subOff", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
